// File: rtl/hetero_coh_sequencer.sv
// Front-end sequencer for the heterogeneous coherence directory: WRR CPU/GPU arbitration,
// single outstanding directory request, probe-ack collection. Optional macro: HCS_ACK_TIMEOUT_EN.
module hetero_coh_sequencer #(
  parameter int N_CPU       = 4,
  parameter int N_GPU       = 8,
  parameter int LINE_ADDR_W = 32,
  parameter int GPU_WEIGHT  = 2,
  parameter int ACK_TIMEOUT = 255,
  localparam int CPU_SRC_W  = (N_CPU > 1) ? $clog2(N_CPU) : 1,
  localparam int GPU_SRC_W  = (N_GPU > 1) ? $clog2(N_GPU) : 1,
  localparam int RESP_SRC_W = (CPU_SRC_W > GPU_SRC_W) ? CPU_SRC_W : GPU_SRC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req_valid,
  output logic                   cpu_req_ready,
  input  logic [LINE_ADDR_W-1:0] cpu_req_addr,
  input  logic [1:0]             cpu_req_type,
  input  logic [CPU_SRC_W-1:0]   cpu_req_src,
  input  logic                   gpu_req_valid,
  output logic                   gpu_req_ready,
  input  logic [LINE_ADDR_W-1:0] gpu_req_addr,
  input  logic [1:0]             gpu_req_type,
  input  logic [GPU_SRC_W-1:0]   gpu_req_src,
  output logic                   dir_req_valid,
  input  logic                   dir_req_ready,
  output logic [LINE_ADDR_W-1:0] dir_req_addr,
  output logic [1:0]             dir_req_type,
  input  logic                   dir_grant,
  input  logic [N_CPU-1:0]       dir_cpu_inval,
  input  logic [N_GPU-1:0]       dir_gpu_inval,
  input  logic [N_CPU-1:0]       cpu_ack,
  input  logic [N_GPU-1:0]       gpu_ack,
  output logic                   resp_valid,
  output logic                   resp_class,
  output logic [RESP_SRC_W-1:0]  resp_src,
  output logic                   resp_err,
  output logic                   busy,
  output logic [2:0]             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; ready never
  // depends on anything but state and valids, and dir_req_* stay stable until accepted.
  localparam int WRR_W = $clog2(GPU_WEIGHT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_DIR = 3'd2,
    S_COLLECT  = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WRR_W-1:0]       r_wrr;
  logic [LINE_ADDR_W-1:0] r_addr;
  logic [1:0]             r_type;
  logic                   r_class;
  logic [RESP_SRC_W-1:0]  r_src;
  logic [N_CPU-1:0]       r_pend_c;
  logic [N_GPU-1:0]       r_pend_g;
  logic                   w_gpu_win;
  logic                   w_cpu_win;
  logic                   w_accept;
  logic [N_CPU-1:0]       w_grant_c;
  logic [N_GPU-1:0]       w_grant_g;
  logic [N_CPU-1:0]       w_coll_c;
  logic [N_GPU-1:0]       w_coll_g;
  logic                   w_timeout;

`ifdef HCS_ACK_TIMEOUT_EN
  localparam int TO_W = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
`endif

  // GPU keeps winning contested rounds until it has won GPU_WEIGHT in a row.
  assign w_gpu_win     = gpu_req_valid && (!cpu_req_valid || (r_wrr < WRR_W'(GPU_WEIGHT)));
  assign w_cpu_win     = cpu_req_valid && !w_gpu_win;
  assign cpu_req_ready = (r_state == S_IDLE) && w_cpu_win;
  assign gpu_req_ready = (r_state == S_IDLE) && w_gpu_win;
  assign w_accept      = cpu_req_ready || gpu_req_ready;

  assign w_grant_c = dir_cpu_inval & ~cpu_ack;
  assign w_grant_g = dir_gpu_inval & ~gpu_ack;
  assign w_coll_c  = r_pend_c & ~cpu_ack;
  assign w_coll_g  = r_pend_g & ~gpu_ack;

`ifdef HCS_ACK_TIMEOUT_EN
  assign w_timeout = (r_state == S_COLLECT) && ((|w_coll_c) || (|w_coll_g)) &&
                     (r_to_cnt == TO_W'(ACK_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE:    if (dir_req_ready) w_state_nxt = S_WAIT_DIR;
      S_WAIT_DIR: begin
        if (!dir_grant)                      w_state_nxt = S_ISSUE;
        else if (!(|w_grant_c) && !(|w_grant_g)) w_state_nxt = S_RESP;
        else                                 w_state_nxt = S_COLLECT;
      end
      S_COLLECT:  if ((!(|w_coll_c) && !(|w_coll_g)) || w_timeout) w_state_nxt = S_RESP;
      S_RESP:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrr    <= '0;
      r_addr   <= '0;
      r_type   <= '0;
      r_class  <= 1'b0;
      r_src    <= '0;
      r_pend_c <= '0;
      r_pend_g <= '0;
    end else begin
      if (w_accept) begin
        r_class <= w_gpu_win;
        if (w_gpu_win) begin
          r_addr <= gpu_req_addr;
          r_type <= gpu_req_type;
          r_src  <= RESP_SRC_W'(gpu_req_src);
          if (r_wrr < WRR_W'(GPU_WEIGHT)) r_wrr <= r_wrr + 1'b1;
        end else begin
          r_addr <= cpu_req_addr;
          r_type <= cpu_req_type;
          r_src  <= RESP_SRC_W'(cpu_req_src);
          r_wrr  <= '0;
        end
      end
      if (r_state == S_WAIT_DIR && dir_grant) begin
        r_pend_c <= w_grant_c;
        r_pend_g <= w_grant_g;
      end else if (r_state == S_COLLECT) begin
        r_pend_c <= w_timeout ? '0 : w_coll_c;
        r_pend_g <= w_timeout ? '0 : w_coll_g;
      end
    end
  end

`ifdef HCS_ACK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
      if (r_state == S_WAIT_DIR)     r_to_cnt <= '0;
      else if (r_state == S_COLLECT) r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
  assign resp_err = (r_state == S_RESP) && r_err;
`else
  assign resp_err = 1'b0;
`endif

  assign dir_req_valid = (r_state == S_ISSUE);
  assign dir_req_addr  = r_addr;
  assign dir_req_type  = r_type;
  assign resp_valid    = (r_state == S_RESP);
  assign resp_class    = r_class;
  assign resp_src      = r_src;
  assign busy          = (r_state != S_IDLE);
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_hetero_coh_sequencer.sv
// Self-checking bench for hetero_coh_sequencer: directed steps plus randomized
// transactions against a transaction-level reference model.
module tb_hetero_coh_sequencer;

  localparam int N_CPU = 4;
  localparam int N_GPU = 8;
  localparam int LINE_ADDR_W = 32;
  localparam int GPU_WEIGHT = 2;
  localparam int ACK_TIMEOUT = 10;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req_valid, cpu_req_ready, gpu_req_valid, gpu_req_ready;
  logic [LINE_ADDR_W-1:0] cpu_req_addr, gpu_req_addr, dir_req_addr;
  logic [1:0] cpu_req_type, gpu_req_type, dir_req_type;
  logic [1:0] cpu_req_src;
  logic [2:0] gpu_req_src;
  logic dir_req_valid, dir_req_ready, dir_grant;
  logic [N_CPU-1:0] dir_cpu_inval, cpu_ack;
  logic [N_GPU-1:0] dir_gpu_inval, gpu_ack;
  logic resp_valid, resp_class, resp_err, busy;
  logic [2:0] resp_src;
  logic [2:0] dbg_state;

  hetero_coh_sequencer #(
    .N_CPU(N_CPU), .N_GPU(N_GPU), .LINE_ADDR_W(LINE_ADDR_W),
    .GPU_WEIGHT(GPU_WEIGHT), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_type(cpu_req_type), .cpu_req_src(cpu_req_src),
    .gpu_req_valid(gpu_req_valid), .gpu_req_ready(gpu_req_ready),
    .gpu_req_addr(gpu_req_addr), .gpu_req_type(gpu_req_type), .gpu_req_src(gpu_req_src),
    .dir_req_valid(dir_req_valid), .dir_req_ready(dir_req_ready),
    .dir_req_addr(dir_req_addr), .dir_req_type(dir_req_type),
    .dir_grant(dir_grant), .dir_cpu_inval(dir_cpu_inval), .dir_gpu_inval(dir_gpu_inval),
    .cpu_ack(cpu_ack), .gpu_ack(gpu_ack),
    .resp_valid(resp_valid), .resp_class(resp_class), .resp_src(resp_src),
    .resp_err(resp_err), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // transaction descriptor driven by run_txn
  logic t_cv, t_gv;
  logic [LINE_ADDR_W-1:0] t_caddr, t_gaddr;
  logic [1:0] t_ctype, t_gtype, t_csrc;
  logic [2:0] t_gsrc;
  int t_stall, t_nogrant;
  logic [N_CPU-1:0] t_cinv, t_cack0;
  logic [N_GPU-1:0] t_ginv, t_gack0;
  logic [N_CPU-1:0] ack_c_q[$];
  logic [N_GPU-1:0] ack_g_q[$];

  // reference model: consecutive GPU wins since the last CPU win (saturating)
  int m_streak;
  logic last_gpu_win;
  int lat_acc, lat_gnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req_valid = 0; gpu_req_valid = 0;
    cpu_req_addr = '0; gpu_req_addr = '0; cpu_req_type = '0; gpu_req_type = '0;
    cpu_req_src = '0; gpu_req_src = '0;
    dir_req_ready = 0; dir_grant = 0; dir_cpu_inval = '0; dir_gpu_inval = '0;
    cpu_ack = '0; gpu_ack = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    m_streak = 0;
  endtask

  task automatic clear_txn();
    t_cv = 0; t_gv = 0; t_caddr = '0; t_gaddr = '0; t_ctype = '0; t_gtype = '0;
    t_csrc = '0; t_gsrc = '0; t_stall = 0; t_nogrant = 0;
    t_cinv = '0; t_ginv = '0; t_cack0 = '0; t_gack0 = '0;
    ack_c_q.delete(); ack_g_q.delete();
  endtask

  // Drives one full transaction; latencies counted in cycles from the accept edge and grant cycle.
  task automatic run_txn(output int la, output int lg);
    logic exp_gpu;
    logic [LINE_ADDR_W-1:0] e_addr;
    logic [1:0] e_type;
    logic [2:0] e_src;
    logic [N_CPU-1:0] pc, ca;
    logic [N_GPU-1:0] pg, ga;
    bit done;
    la = 0; lg = 0; done = 0;
    cpu_req_valid = t_cv; cpu_req_addr = t_caddr; cpu_req_type = t_ctype; cpu_req_src = t_csrc;
    gpu_req_valid = t_gv; gpu_req_addr = t_gaddr; gpu_req_type = t_gtype; gpu_req_src = t_gsrc;
    #1;
    exp_gpu = t_gv && (!t_cv || m_streak < GPU_WEIGHT);
    check("cpu_req_ready", cpu_req_ready, t_cv && !exp_gpu);
    check("gpu_req_ready", gpu_req_ready, exp_gpu);
    check("idle_busy", busy, 0);
    last_gpu_win = gpu_req_ready;
    if (exp_gpu) m_streak = (m_streak < GPU_WEIGHT) ? m_streak + 1 : m_streak;
    else         m_streak = 0;
    e_addr = exp_gpu ? t_gaddr : t_caddr;
    e_type = exp_gpu ? t_gtype : t_ctype;
    e_src  = exp_gpu ? t_gsrc : {1'b0, t_csrc};
    tick(); la = 1;
    cpu_req_valid = 0; gpu_req_valid = 0;
    for (int r = 0; r <= t_nogrant; r++) begin
      for (int s = 0; s < t_stall; s++) begin
        check("issue_stall_valid", dir_req_valid, 1);
        check("issue_stall_addr", dir_req_addr, e_addr);
        tick(); la++;
      end
      dir_req_ready = 1;
      check("issue_valid", dir_req_valid, 1);
      check("issue_addr", dir_req_addr, e_addr);
      check("issue_type", dir_req_type, e_type);
      tick(); la++;
      dir_req_ready = 0;
      if (r == t_nogrant) begin
        dir_grant = 1; dir_cpu_inval = t_cinv; dir_gpu_inval = t_ginv;
        cpu_ack = t_cack0; gpu_ack = t_gack0;
      end
      check("wait_dir_valid", dir_req_valid, 0);
      tick(); la++;
      dir_grant = 0; dir_cpu_inval = '0; dir_gpu_inval = '0; cpu_ack = '0; gpu_ack = '0;
    end
    pc = t_cinv & ~t_cack0;
    pg = t_ginv & ~t_gack0;
    lg = 1;
    for (int k = 0; k < 200 && !done; k++) begin
      if (pc == 0 && pg == 0) begin
        check("resp_valid", resp_valid, 1);
        check("resp_class", resp_class, exp_gpu);
        check("resp_src", resp_src, e_src);
        check("resp_err", resp_err, 0);
        done = 1;
      end else begin
        check("collect_no_resp", resp_valid, 0);
        ca = (ack_c_q.size() > 0) ? ack_c_q.pop_front() : '0;
        ga = (ack_g_q.size() > 0) ? ack_g_q.pop_front() : '0;
        cpu_ack = ca; gpu_ack = ga;
        pc = pc & ~ca;
        pg = pg & ~ga;
        tick(); la++; lg++;
        cpu_ack = '0; gpu_ack = '0;
      end
    end
    if (!done) check("resp_wait_bound", 0, 1);
    tick();
    check("post_resp_busy", busy, 0);
    check("post_resp_valid", resp_valid, 0);
    clear_txn();
  endtask

  initial begin
    clear_txn();
    do_reset();

    // reset state
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_dir_valid", dir_req_valid, 0);
    check("rst_dir_addr", dir_req_addr, 0);
    check("rst_cpu_ready", cpu_req_ready, 0);
    check("rst_gpu_ready", gpu_req_ready, 0);
    check("rst_resp_err", resp_err, 0);

    // CPU read 0x40, no invalidations: minimum latency
    t_cv = 1; t_caddr = 32'h40; t_ctype = 0; t_csrc = 2;
    run_txn(lat_acc, lat_gnt);
    check("min_latency", lat_acc, 3);

    // both valid each round: G,G,C,G,G,C
    for (int i = 0; i < 6; i++) begin
      t_cv = 1; t_gv = 1;
      t_caddr = 32'h1000 + i; t_gaddr = 32'h2000 + i;
      t_csrc = 2'(i); t_gsrc = 3'(i + 1); t_ctype = 0; t_gtype = 1;
      run_txn(lat_acc, lat_gnt);
      check("wrr_order", last_gpu_win, (i % 3) != 2);
    end

    // GPU write, CPU invals 0101, acks bit0 at +2 and bit2 at +5
    t_gv = 1; t_gaddr = 32'hABCD0; t_gtype = 1; t_gsrc = 5; t_cinv = 4'b0101;
    ack_c_q = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0100};
    run_txn(lat_acc, lat_gnt);
    check("collect_latency", lat_gnt, 6);

    // one grant refusal -> reissue same payload
    t_cv = 1; t_caddr = 32'h7700; t_ctype = 1; t_csrc = 1; t_nogrant = 1; t_stall = 1;
    run_txn(lat_acc, lat_gnt);
    check("retry_latency", lat_acc, 7);

    // ack coincident with grant retires the only inval
    t_cv = 1; t_caddr = 32'h88; t_csrc = 3; t_cinv = 4'b0001; t_cack0 = 4'b0001;
    run_txn(lat_acc, lat_gnt);
    check("skip_collect", lat_gnt, 1);

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      int sel, nq;
      sel = $urandom_range(0, 2);
      t_cv = (sel != 1); t_gv = (sel != 0);
      t_caddr = $urandom; t_gaddr = $urandom;
      t_ctype = 2'($urandom_range(0, 1)); t_gtype = 2'($urandom_range(0, 1));
      t_csrc = 2'($urandom_range(0, 3)); t_gsrc = 3'($urandom_range(0, 7));
      t_stall = $urandom_range(0, 2); t_nogrant = $urandom_range(0, 2);
      t_cinv = 4'($urandom); t_ginv = 8'($urandom);
      t_cack0 = 4'($urandom); t_gack0 = 8'($urandom);
      nq = $urandom_range(0, 6);
      for (int k = 0; k < nq; k++) begin
        ack_c_q.push_back(4'($urandom));
        ack_g_q.push_back(8'($urandom));
      end
      ack_c_q.push_back('1);
      ack_g_q.push_back('1);
      run_txn(lat_acc, lat_gnt);
    end

    // reset in the middle of ack collection
    cpu_req_valid = 1; cpu_req_addr = 32'h55; cpu_req_src = 1;
    tick();
    cpu_req_valid = 0; dir_req_ready = 1;
    tick();
    dir_req_ready = 0; dir_grant = 1; dir_cpu_inval = 4'b1111;
    tick();
    dir_grant = 0; dir_cpu_inval = '0;
    check("midop_busy", busy, 1);
    rst = 1;
    tick();
    rst = 0; m_streak = 0;
    check("midop_rst_busy", busy, 0);
    check("midop_rst_dir_valid", dir_req_valid, 0);
    for (int k = 0; k < 4; k++) begin
      check("midop_no_resp", resp_valid, 0);
      tick();
    end
    t_gv = 1; t_gaddr = 32'h99; t_gsrc = 7;
    run_txn(lat_acc, lat_gnt);
    check("post_rst_latency", lat_acc, 3);

`ifdef HCS_ACK_TIMEOUT_EN
    begin
      int cyc;
      bit seen;
      seen = 0; cyc = 0;
      cpu_req_valid = 1; cpu_req_addr = 32'h123; cpu_req_src = 2;
      tick();
      cpu_req_valid = 0; dir_req_ready = 1;
      tick();
      dir_req_ready = 0; dir_grant = 1; dir_cpu_inval = 4'b0001;
      tick();
      dir_grant = 0; dir_cpu_inval = '0;
      for (int k = 1; k < 100 && !seen; k++) begin
        if (resp_valid) begin
          seen = 1; cyc = k;
          check("timeout_err", resp_err, 1);
        end else tick();
      end
      check("timeout_latency", cyc, ACK_TIMEOUT + 1);
      tick();
      m_streak = 0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
